// File: rtl/ijvm_fetch_unit.sv
// IJVM instruction fetch unit: streams sequential bytes from the fetch PC into a
// small prefetch queue that exposes the next opcode (mbr1) and 16-bit operand (mbr2).
module ijvm_fetch_unit #(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned QUEUE_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pc_load,
    input  logic [ADDRESS_WIDTH-1:0]   pc_in,
    input  logic                       consume1,
    input  logic                       consume2,
    output logic                       fetch,
    output logic [ADDRESS_WIDTH-1:0]   byte_address,
    input  logic [WORD_WIDTH-1:0]      byte_data,
    output logic [WORD_WIDTH-1:0]      mbr1,
    output logic                       mbr1_valid,
    output logic [2*WORD_WIDTH-1:0]    mbr2,
    output logic                       mbr2_valid,
    output logic [ADDRESS_WIDTH-1:0]   pc_out
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

    logic [ADDRESS_WIDTH-1:0] fpc_q, fpc_d;
    logic [ADDRESS_WIDTH-1:0] head_pc_q, head_pc_d;
    logic                     inflight_q, inflight_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [WORD_WIDTH-1:0]    mem_q [QUEUE_DEPTH];

    logic [CW:0]              occupancy;
    logic                     push;
    logic [1:0]               pop_n;
    logic [PW-1:0]            rd_ptr_p1;

    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign fetch      = rst_n && !pc_load && (occupancy < DEPTH_W);
    assign byte_address = fpc_q;
    assign push       = inflight_q && !pc_load;

    assign mbr1_valid = (count_q >= CW'(1));
    assign mbr2_valid = (count_q >= CW'(2));
    assign rd_ptr_p1  = rd_ptr_q + PW'(1);
    assign mbr1       = mbr1_valid ? mem_q[rd_ptr_q] : '0;
    assign mbr2       = mbr2_valid ? {mem_q[rd_ptr_q], mem_q[rd_ptr_p1]} : '0;
    assign pc_out     = head_pc_q;

    // consume2 wins over consume1; a consume the queue cannot satisfy is dropped.
    always_comb begin
        pop_n = 2'd0;
        if (!pc_load) begin
            if (consume2 && mbr2_valid)
                pop_n = 2'd2;
            else if (consume1 && mbr1_valid)
                pop_n = 2'd1;
        end
    end

    always_comb begin
        fpc_d      = fpc_q;
        head_pc_d  = head_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (pc_load) begin
            fpc_d     = pc_in;
            head_pc_d = pc_in;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (fetch) begin
                fpc_d      = fpc_q + ADDRESS_WIDTH'(1);
                inflight_d = 1'b1;
            end
            if (push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d  = rd_ptr_q + PW'(pop_n);
            head_pc_d = head_pc_q + ADDRESS_WIDTH'(pop_n);
            count_d   = count_q + CW'(push) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= '0;
            head_pc_q  <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= byte_data;
    end

endmodule

// File: tb/tb_ijvm_fetch_unit.sv
// Self-checking bench for ijvm_fetch_unit with a byte-memory responder and
// a scoreboard of issued bytes for the streaming scenario.
module tb_ijvm_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = '0;
    logic        consume1 = 1'b0;
    logic        consume2 = 1'b0;
    logic        fetch;
    logic [31:0] byte_address;
    logic [7:0]  byte_data = '0;
    logic [7:0]  mbr1;
    logic        mbr1_valid;
    logic [15:0] mbr2;
    logic        mbr2_valid;
    logic [31:0] pc_out;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    bit sb_en = 1'b0;

    always #5 clk = ~clk;

    ijvm_fetch_unit #(.WORD_WIDTH(8), .ADDRESS_WIDTH(32), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
        .consume1(consume1), .consume2(consume2), .fetch(fetch),
        .byte_address(byte_address), .byte_data(byte_data), .mbr1(mbr1),
        .mbr1_valid(mbr1_valid), .mbr2(mbr2), .mbr2_valid(mbr2_valid), .pc_out(pc_out)
    );

    function automatic logic [7:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h10;
            32'h0000_0001: return 8'h2A;
            32'h0000_0002: return 8'h36;
            32'h0000_0003: return 8'h01;
            32'h0000_0004: return 8'hA7;
            32'h0000_0005: return 8'hFF;
            32'h0000_0040: return 8'h99;
            32'hFFFF_FFFE: return 8'hC3;
            32'hFFFF_FFFF: return 8'h5E;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Memory responds one cycle after a sampled request; the scoreboard records issue order.
    always @(posedge clk) begin
        if (fetch) byte_data <= memf(byte_address);
        if (sb_en && fetch) sb.push_back(memf(byte_address));
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (fetch !== 1'b0) begin failures++; $display("FAIL reset_fetch got=%b exp=0", fetch); end
        checks++; if ({mbr1_valid, mbr2_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {mbr1_valid, mbr2_valid}); end
        checks++; if ({mbr1, mbr2, pc_out} !== 56'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mbr1, mbr2, pc_out}); end
    endtask

    task automatic test_cold_start();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h0}) begin failures++; $display("FAIL cold_issue got=%b/%h exp=1/00000000", fetch, byte_address); end
        @(negedge clk);
        checks++; if (mbr1_valid !== 1'b0) begin failures++; $display("FAIL cold_latency got=%b exp=0", mbr1_valid); end
        @(negedge clk);
        checks++; if ({mbr1_valid, mbr1} !== {1'b1, 8'h10}) begin failures++; $display("FAIL cold_mbr1 got=%b/%h exp=1/10", mbr1_valid, mbr1); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b0, 32'h4}) begin failures++; $display("FAIL cold_full_stop got=%b/%h exp=0/00000004", fetch, byte_address); end
        @(negedge clk);
        checks++; if ({mbr2_valid, mbr2, pc_out} !== {1'b1, 16'h102A, 32'h0}) begin failures++; $display("FAIL cold_mbr2 got=%b/%h/%h exp=1/102a/00000000", mbr2_valid, mbr2, pc_out); end
        @(negedge clk);
        checks++; if (fetch !== 1'b0) begin failures++; $display("FAIL cold_full_hold got=%b exp=0", fetch); end
    endtask

    task automatic test_consume1();
        @(posedge clk); #1 consume1 = 1'b1;
        @(posedge clk); #1 consume1 = 1'b0;
        @(negedge clk);
        checks++; if ({mbr1, mbr2, pc_out} !== {8'h2A, 16'h2A36, 32'h1}) begin failures++; $display("FAIL c1_data got=%h/%h/%h exp=2a/2a36/00000001", mbr1, mbr2, pc_out); end
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h4}) begin failures++; $display("FAIL c1_refetch got=%b/%h exp=1/00000004", fetch, byte_address); end
    endtask

    task automatic test_both();
        @(posedge clk); #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if ({fetch, mbr2} !== {1'b0, 16'h102A}) begin failures++; $display("FAIL both_prefill got=%b/%h exp=0/102a", fetch, mbr2); end
        consume1 = 1'b1; consume2 = 1'b1;
        @(posedge clk); #1 consume1 = 1'b0; consume2 = 1'b0;
        @(negedge clk);
        checks++; if ({mbr1, mbr2, pc_out} !== {8'h36, 16'h3601, 32'h2}) begin failures++; $display("FAIL both_pop2 got=%h/%h/%h exp=36/3601/00000002", mbr1, mbr2, pc_out); end
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h4}) begin failures++; $display("FAIL both_refetch got=%b/%h exp=1/00000004", fetch, byte_address); end
    endtask

    task automatic test_redirect();
        @(posedge clk); #1 pc_load = 1'b1; pc_in = 32'h40; consume1 = 1'b1;
        @(negedge clk);
        checks++; if (fetch !== 1'b0) begin failures++; $display("FAIL redir_fetch_gate got=%b exp=0", fetch); end
        @(posedge clk); #1 pc_load = 1'b0; consume1 = 1'b0;
        @(negedge clk);
        checks++; if ({mbr1_valid, pc_out} !== {1'b0, 32'h40}) begin failures++; $display("FAIL redir_flush got=%b/%h exp=0/00000040", mbr1_valid, pc_out); end
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h40}) begin failures++; $display("FAIL redir_issue got=%b/%h exp=1/00000040", fetch, byte_address); end
        @(negedge clk);
        checks++; if (mbr1_valid !== 1'b0) begin failures++; $display("FAIL redir_stale got=%b exp=0", mbr1_valid); end
        @(posedge clk); #1;
        checks++; if ({mbr1_valid, mbr1, pc_out} !== {1'b1, 8'h99, 32'h40}) begin failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/99/00000040", mbr1_valid, mbr1, pc_out); end
    endtask

    task automatic test_consume2_short();
        consume2 = 1'b1;
        @(posedge clk); #1 consume2 = 1'b0;
        @(negedge clk);
        checks++; if ({mbr1, pc_out} !== {8'h99, 32'h40}) begin failures++; $display("FAIL c2short_nopop got=%h/%h exp=99/00000040", mbr1, pc_out); end
        checks++; if ({mbr2_valid, mbr2} !== {1'b1, 16'h991B}) begin failures++; $display("FAIL c2short_mbr2 got=%b/%h exp=1/991b", mbr2_valid, mbr2); end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1 pc_load = 1'b1; pc_in = 32'hFFFF_FFFE;
        @(posedge clk); #1 pc_load = 1'b0;
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b1, 32'hFFFF_FFFE}) begin failures++; $display("FAIL wrap_addr0 got=%b/%h exp=1/fffffffe", fetch, byte_address); end
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b1, 32'hFFFF_FFFF}) begin failures++; $display("FAIL wrap_addr1 got=%b/%h exp=1/ffffffff", fetch, byte_address); end
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wrap_addr2 got=%b/%h exp=1/00000000", fetch, byte_address); end
        @(negedge clk);
        checks++; if ({mbr2_valid, mbr2, pc_out} !== {1'b1, 16'hC35E, 32'hFFFF_FFFE}) begin failures++; $display("FAIL wrap_mbr2 got=%b/%h/%h exp=1/c35e/fffffffe", mbr2_valid, mbr2, pc_out); end
        @(posedge clk); #1 consume2 = 1'b1;
        @(posedge clk); #1 consume2 = 1'b0;
        @(negedge clk);
        checks++; if ({mbr1, mbr2, pc_out} !== {8'h10, 16'h102A, 32'h0}) begin failures++; $display("FAIL wrap_headpc got=%h/%h/%h exp=10/102a/00000000", mbr1, mbr2, pc_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [15:0] exp2;
        int popped;
        int n;
        @(posedge clk); #1 pc_load = 1'b1; pc_in = 32'h100;
        @(posedge clk); #1 pc_load = 1'b0;
        sb.delete();
        sb_en = 1'b1;
        exp_pc = 32'h100;
        popped = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = 0;
            if (mbr2_valid && (i % 3 == 0)) begin
                exp2 = (sb.size() >= 2) ? {sb[0], sb[1]} : 16'hxxxx;
                checks++; if (mbr2 !== exp2) begin failures++; $display("FAIL b2b_mbr2 cycle=%0d got=%h exp=%h", i, mbr2, exp2); end
                consume2 = 1'b1; n = 2;
            end else if (mbr1_valid) begin
                exp2 = (sb.size() >= 1) ? {8'h00, sb[0]} : 16'hxxxx;
                checks++; if ({8'h00, mbr1} !== exp2) begin failures++; $display("FAIL b2b_mbr1 cycle=%0d got=%h exp=%h", i, mbr1, exp2[7:0]); end
                consume1 = 1'b1; n = 1;
            end
            checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL b2b_pc cycle=%0d got=%h exp=%h", i, pc_out, exp_pc); end
            @(posedge clk); #1 consume1 = 1'b0; consume2 = 1'b0;
            for (int k = 0; k < n; k++) if (sb.size() > 0) void'(sb.pop_front());
            exp_pc += 32'(n);
            popped += n;
        end
        checks++; if (popped < 30) begin failures++; $display("FAIL b2b_throughput got=%0d exp>=30", popped); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #3 rst_n = 1'b0;
        sb_en = 1'b0;
        #1;
        checks++; if ({fetch, mbr1_valid, mbr2_valid} !== 3'b000) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {fetch, mbr1_valid, mbr2_valid}); end
        checks++; if ({mbr1, mbr2, pc_out} !== 56'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", {mbr1, mbr2, pc_out}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({fetch, byte_address} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rstmid_restart got=%b/%h exp=1/00000000", fetch, byte_address); end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_consume1();
        test_both();
        test_redirect();
        test_consume2_short();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
